// File: rtl/wb_write_arbiter_pkg.sv
// wb_write_arbiter_pkg: shared widths, defaults and the long-latency FIFO entry type
package wb_write_arbiter_pkg;
  localparam int REG_W = 32;
  localparam int ADDR_W = 5;
  localparam int WB_FIFO_DEPTH = 2;
  localparam int WB_STARVE_MAX = 4;
  typedef struct packed {
    logic [ADDR_W-1:0] waddr;
    logic [REG_W-1:0]  wdata;
  } wb_entry_t;
endpackage

// File: rtl/wb_write_arbiter_ll_fifo.sv
// wb_ll_fifo: long-latency result queue with per-entry live bits, kill-by-address and two CAM lookups
module wb_ll_fifo
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  wb_entry_t         push_entry,
  input  logic              pop,
  input  logic              kill,
  input  logic [ADDR_W-1:0] kill_addr,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              hit1,
  output logic              hit2,
  output logic              full,
  output logic              empty,
  output wb_entry_t         head,
  output logic              head_live
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [AW-1:0] wr_idx, rd_idx;
  logic [DEPTH-1:0] live, live_nxt;
  wb_entry_t mem [DEPTH];
  assign wr_idx = wr_ptr[AW-1:0];
  assign rd_idx = rd_ptr[AW-1:0];
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_idx == rd_idx);
  assign head = mem[rd_idx];
  assign head_live = live[rd_idx];
  // live implies occupied: bits are only set on push and cleared on pop
  always_comb begin
    hit1 = 1'b0;
    hit2 = 1'b0;
    live_nxt = live;
    for (int i = 0; i < DEPTH; i++) begin
      hit1 = hit1 | (live[i] && raddr1 != '0 && mem[i].waddr == raddr1);
      hit2 = hit2 | (live[i] && raddr2 != '0 && mem[i].waddr == raddr2);
      if (kill && mem[i].waddr == kill_addr) live_nxt[i] = 1'b0;
    end
    if (pop) live_nxt[rd_idx] = 1'b0;
    if (push) live_nxt[wr_idx] = push_entry.waddr != '0 && !(kill && push_entry.waddr == kill_addr);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      live <= '0;
    end else begin
      live <= live_nxt;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) rd_ptr <= rd_ptr + PW'(1);
    end
  end
  always_ff @(posedge clk) if (push) mem[wr_idx] <= push_entry;
endmodule

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: merges pipeline writebacks with queued long-latency results onto one regfile write port
module wb_write_arbiter
  import wb_write_arbiter_pkg::*;
#(
  parameter int DEPTH = WB_FIFO_DEPTH,
  parameter int STARVE_MAX = WB_STARVE_MAX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pl_we,
  input  logic [ADDR_W-1:0] pl_waddr,
  input  logic [REG_W-1:0]  pl_wdata,
  input  logic              ll_valid,
  output logic              ll_ready,
  input  logic [ADDR_W-1:0] ll_waddr,
  input  logic [REG_W-1:0]  ll_wdata,
  input  logic [ADDR_W-1:0] raddr1,
  input  logic [ADDR_W-1:0] raddr2,
  output logic              pend_hit1,
  output logic              pend_hit2,
  output logic              stall_req,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [REG_W-1:0]  rf_wdata
);
  localparam int CW = $clog2(STARVE_MAX + 1);
  logic full, empty, head_live, hit1, hit2, push, pop, kill, head_wr;
  logic [CW-1:0] cnt;
  wb_entry_t head;
  wb_ll_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .push_entry('{waddr: ll_waddr, wdata: ll_wdata}),
    .pop(pop), .kill(kill), .kill_addr(pl_waddr), .raddr1(raddr1), .raddr2(raddr2),
    .hit1(hit1), .hit2(hit2), .full(full), .empty(empty), .head(head), .head_live(head_live)
  );
  assign ll_ready = !rst && !full;
  assign push = ll_valid && ll_ready;
  assign pop = !rst && !pl_we && !empty;
  assign kill = pl_we && pl_waddr != '0;
  assign head_wr = !empty && head_live;
  assign pend_hit1 = !rst && hit1;
  assign pend_hit2 = !rst && hit2;
  assign stall_req = !rst && cnt == CW'(STARVE_MAX);
  always_comb begin
    rf_we = !rst && (pl_we || head_wr);
    rf_waddr = rst ? '0 : pl_we ? pl_waddr : head_wr ? head.waddr : '0;
    rf_wdata = rst ? '0 : pl_we ? pl_wdata : head_wr ? head.wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else cnt <= (pl_we && !empty) ? ((cnt == CW'(STARVE_MAX)) ? cnt : cnt + CW'(1)) : '0;
  end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: directed and random stimulus checked against a queue-based reference model
module tb_wb_write_arbiter;
  import wb_write_arbiter_pkg::*;
  logic clk = 1'b0;
  logic rst, pl_we, ll_valid, ll_ready, pend_hit1, pend_hit2, stall_req, rf_we;
  logic [ADDR_W-1:0] pl_waddr, ll_waddr, raddr1, raddr2, rf_waddr;
  logic [REG_W-1:0] pl_wdata, ll_wdata, rf_wdata;
  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [REG_W-1:0]  d;
    bit                live;
  } ent_t;
  ent_t q[$];
  int starve = 0;
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  wb_write_arbiter dut (
    .clk(clk), .rst(rst), .pl_we(pl_we), .pl_waddr(pl_waddr), .pl_wdata(pl_wdata),
    .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
    .raddr1(raddr1), .raddr2(raddr2), .pend_hit1(pend_hit1), .pend_hit2(pend_hit2),
    .stall_req(stall_req), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic r, input logic we, input logic [ADDR_W-1:0] wa, input logic [REG_W-1:0] wd,
                       input logic v, input logic [ADDR_W-1:0] la, input logic [REG_W-1:0] ld,
                       input logic [ADDR_W-1:0] r1, input logic [ADDR_W-1:0] r2);
    rst = r; pl_we = we; pl_waddr = wa; pl_wdata = wd;
    ll_valid = v; ll_waddr = la; ll_wdata = ld; raddr1 = r1; raddr2 = r2;
  endtask
  task automatic model_check();
    logic e_we, h1, h2;
    logic [ADDR_W-1:0] e_a;
    logic [REG_W-1:0] e_d;
    @(negedge clk);
    e_we = 0; e_a = '0; e_d = '0; h1 = 0; h2 = 0;
    if (!rst) begin
      if (pl_we) begin e_we = 1; e_a = pl_waddr; e_d = pl_wdata; end
      else if (q.size() > 0 && q[0].live) begin e_we = 1; e_a = q[0].a; e_d = q[0].d; end
      foreach (q[i]) if (q[i].live) begin
        h1 = h1 | (raddr1 != 0 && q[i].a == raddr1);
        h2 = h2 | (raddr2 != 0 && q[i].a == raddr2);
      end
    end
    chk("rf_we", 32'(rf_we), 32'(e_we));
    chk("rf_waddr", 32'(rf_waddr), 32'(e_a));
    chk("rf_wdata", rf_wdata, e_d);
    chk("ll_ready", 32'(ll_ready), 32'(!rst && q.size() < WB_FIFO_DEPTH));
    chk("pend_hit1", 32'(pend_hit1), 32'(h1));
    chk("pend_hit2", 32'(pend_hit2), 32'(h2));
    chk("stall_req", 32'(stall_req), 32'(!rst && starve == WB_STARVE_MAX));
  endtask
  task automatic model_edge();
    bit ready;
    @(posedge clk);
    if (rst) begin
      q.delete();
      starve = 0;
    end else begin
      ready = q.size() < WB_FIFO_DEPTH;
      starve = (pl_we && q.size() > 0) ? ((starve < WB_STARVE_MAX) ? starve + 1 : starve) : 0;
      if (!pl_we && q.size() > 0) void'(q.pop_front());
      if (pl_we && pl_waddr != 0) foreach (q[i]) if (q[i].a == pl_waddr) q[i].live = 0;
      if (ll_valid && ready) q.push_back('{ll_waddr, ll_wdata, ll_waddr != 0 && !(pl_we && pl_waddr == ll_waddr)});
    end
    #1;
  endtask
  task automatic step();
    model_check();
    model_edge();
  endtask
  initial begin
    int acc;
    drive(1, 0, 0, 0, 1, 5, 32'h55, 5, 0);
    for (int i = 0; i < 2; i++) begin
      model_check();
      chk("rst_we", 32'(rf_we), 0);
      chk("rst_ready", 32'(ll_ready), 0);
      chk("rst_hit", 32'(pend_hit1), 0);
      model_edge();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 5, 0);
    model_check();
    chk("post_rst_ready", 32'(ll_ready), 1);
    chk("post_rst_hit", 32'(pend_hit1), 0);
    model_edge();
    drive(0, 0, 0, 0, 1, 5, 32'h1234, 0, 0);
    model_check();
    chk("no_bypass", 32'(rf_we), 0);
    model_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_check();
    chk("ll_we", 32'(rf_we), 1);
    chk("ll_addr", 32'(rf_waddr), 5);
    chk("ll_data", rf_wdata, 32'h1234);
    model_edge();
    step();
    drive(0, 1, 3, 32'h11, 1, 7, 32'hAA, 7, 0);
    step();
    drive(0, 1, 3, 32'h11, 0, 0, 0, 7, 0);
    for (int i = 0; i < 2; i++) begin
      model_check();
      chk("prio_addr", 32'(rf_waddr), 3);
      chk("prio_hit", 32'(pend_hit1), 1);
      model_edge();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 7, 0);
    model_check();
    chk("prio_drain_addr", 32'(rf_waddr), 7);
    chk("prio_drain_data", rf_wdata, 32'hAA);
    model_edge();
    drive(0, 0, 0, 0, 1, 9, 32'hDEAD, 9, 9);
    step();
    drive(0, 1, 9, 32'hBEEF, 0, 0, 0, 9, 9);
    model_check();
    chk("waw_data", rf_wdata, 32'hBEEF);
    chk("waw_hit_before", 32'(pend_hit1), 1);
    model_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 9, 9);
    model_check();
    chk("waw_dead_we", 32'(rf_we), 0);
    chk("waw_hit_after", 32'(pend_hit2), 0);
    model_edge();
    for (int i = 0; i < 2; i++) begin
      drive(0, 1, 1, 32'h100 + i, 1, 5'(10 + i), $urandom, 0, 0);
      step();
    end
    drive(0, 1, 1, 32'h200, 1, 12, 32'h12, 10, 11);
    model_check();
    chk("full_ready", 32'(ll_ready), 0);
    model_edge();
    acc = 0;
    for (int i = 0; i < 40 && acc < 6; i++) begin
      if (q.size() < WB_FIFO_DEPTH) acc++;
      drive(0, 0, 0, 0, 1, 5'(12 + acc), $urandom, 5'(12 + acc), 0);
      step();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step();
    drive(0, 0, 0, 0, 1, 20, 32'h2020, 0, 0);
    step();
    drive(0, 1, 2, 32'h22, 0, 0, 0, 20, 0);
    for (int i = 0; i < 4; i++) begin
      model_check();
      chk("stall_pre", 32'(stall_req), 0);
      model_edge();
    end
    model_check();
    chk("stall_on", 32'(stall_req), 1);
    model_edge();
    drive(0, 0, 0, 0, 0, 0, 0, 20, 0);
    step();
    model_check();
    chk("stall_off", 32'(stall_req), 0);
    model_edge();
    drive(0, 0, 0, 0, 1, 0, 32'hFFFF, 0, 0);
    step();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    model_check();
    chk("x0_never_written", 32'(rf_we), 0);
    model_edge();
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 49) == 0, $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 6, 5'($urandom_range(0, 7)), $urandom,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      step();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
